pipeline_hazard_ctrl: RTL and testbench

Central sequencer for the 5-stage 16-bit pipeline. It drives the enable and flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC, and generates EX-stage operand forwarding selects. It detects load-use hazards, applies branch flushes and freezes the pipeline while data memory is busy. A memory-wait timeout FSM and a saturating stall-cycle counter are included.

---
 rtl/pipeline_hazard_ctrl.sv | 173 +++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall sequencer for the 5-stage pipeline: pipeline-register enables/flushes,
// EX operand forwarding selects, memory-wait timeout FSM and a saturating stall counter.
module pipeline_hazard_ctrl #(
   parameter int MEM_TIMEOUT  = 16,
   parameter int CNT_W        = 16,
   parameter bit R0_HARDWIRED = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       id_raddr1,
   input  logic [3:0]       id_raddr2,
   input  logic             id_use1,
   input  logic             id_use2,
   input  logic [3:0]       ex_raddr1,
   input  logic [3:0]       ex_raddr2,
   input  logic [3:0]       idex_rfwaddr,
   input  logic             idex_rfwen,
   input  logic             idex_is_load,
   input  logic [3:0]       exmem_rfwaddr,
   input  logic             exmem_rfwen,
   input  logic [3:0]       memwb_rfwaddr,
   input  logic             memwb_rfwen,
   input  logic             ex_branch_taken,
   input  logic             dm_req,
   input  logic             dm_ready,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             ifid_flush,
   output logic             idex_en,
   output logic             idex_flush,
   output logic             exmem_en,
   output logic             memwb_flush,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [1:0]       dbg_state
);

   localparam logic [1:0] ST_RUN  = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_ERR  = 2'd2;

   localparam int             WCW      = $clog2(MEM_TIMEOUT + 2);
   localparam logic [WCW-1:0] TO_VAL   = WCW'(MEM_TIMEOUT);
   localparam logic [WCW-1:0] WAIT_ONE = WCW'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [1:0]       state_q, state_d;
   logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic             run_mode;
   logic             load_use;

   function automatic logic reg_match(input logic [3:0] waddr, input logic wen,
                                      input logic [3:0] raddr);
      return wen && (waddr == raddr) && ((R0_HARDWIRED == 1'b0) || (raddr != 4'd0));
   endfunction

   // dm_req/dm_ready: an access is in flight from the cycle dm_req is seen without
   // dm_ready until the cycle dm_ready is high; the pipeline is frozen in between.
   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      run_mode    = 1'b0;
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b0;
      idex_en     = 1'b0;
      idex_flush  = 1'b0;
      exmem_en    = 1'b0;
      memwb_flush = 1'b0;
      fwd_a       = 2'b00;
      fwd_b       = 2'b00;

      load_use = idex_is_load &&
                 ((id_use1 && reg_match(idex_rfwaddr, idex_rfwen, id_raddr1)) ||
                  (id_use2 && reg_match(idex_rfwaddr, idex_rfwen, id_raddr2)));

      case (state_q)
         ST_RUN: begin
            if (dm_req && !dm_ready) begin
               memwb_flush = 1'b1;
               state_d     = ST_WAIT;
               wait_cnt_d  = WAIT_ONE;
            end else begin
               run_mode = 1'b1;
            end
         end
         ST_WAIT: begin
            if (dm_ready) begin
               run_mode   = 1'b1;
               state_d    = ST_RUN;
               wait_cnt_d = '0;
            end else begin
               memwb_flush = 1'b1;
               wait_cnt_d  = wait_cnt_q + WAIT_ONE;
               if (wait_cnt_d >= TO_VAL) begin
                  state_d = ST_ERR;
               end
            end
         end
         ST_ERR: begin
            state_d = ST_ERR;
         end
         default: begin
            state_d    = ST_RUN;
            wait_cnt_d = '0;
         end
      endcase

      // A taken branch discards the ID instruction, so it outranks a load-use bubble.
      if (run_mode) begin
         pc_en    = 1'b1;
         ifid_en  = 1'b1;
         idex_en  = 1'b1;
         exmem_en = 1'b1;
         if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
         end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
         end
      end

      if (reg_match(exmem_rfwaddr, exmem_rfwen, ex_raddr1)) begin
         fwd_a = 2'b01;
      end else if (reg_match(memwb_rfwaddr, memwb_rfwen, ex_raddr1)) begin
         fwd_a = 2'b10;
      end
      if (reg_match(exmem_rfwaddr, exmem_rfwen, ex_raddr2)) begin
         fwd_b = 2'b01;
      end else if (reg_match(memwb_rfwaddr, memwb_rfwen, ex_raddr2)) begin
         fwd_b = 2'b10;
      end

      if (!rst) begin
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         ifid_flush  = 1'b0;
         idex_en     = 1'b0;
         idex_flush  = 1'b0;
         exmem_en    = 1'b0;
         memwb_flush = 1'b0;
         fwd_a       = 2'b00;
         fwd_b       = 2'b00;
      end

      stall_cnt_d = stall_cnt_q;
      if (!pc_en && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_RUN;
         wait_cnt_q  <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign mem_err   = (state_q == ST_ERR);
   assign stall_cnt = stall_cnt_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: expected controls, stall count and state are
// queued per cycle and compared against the DUT mid-cycle.
module tb_pipeline_hazard_ctrl;

   localparam logic [1:0] S_RUN  = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_ERR  = 2'd2;

   // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush, fwd_a, fwd_b, mem_err}
   localparam logic [11:0] C_RUN  = 12'b1101010_00_00_0;
   localparam logic [11:0] C_LU   = 12'b0001110_00_00_0;
   localparam logic [11:0] C_BR   = 12'b1111110_00_00_0;
   localparam logic [11:0] C_WAIT = 12'b0000001_00_00_0;
   localparam logic [11:0] C_ERR  = 12'b0000000_00_00_1;
   localparam logic [11:0] C_ZERO = 12'b0000000_00_00_0;

   logic clk = 1'b0;
   logic rst;
   logic [3:0] id_raddr1, id_raddr2, ex_raddr1, ex_raddr2;
   logic [3:0] idex_rfwaddr, exmem_rfwaddr, memwb_rfwaddr;
   logic id_use1, id_use2, idex_rfwen, idex_is_load, exmem_rfwen, memwb_rfwen;
   logic ex_branch_taken, dm_req, dm_ready;

   logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush, mem_err;
   logic [1:0] fwd_a, fwd_b, dbg_state;
   logic [15:0] stall_cnt;

   logic s_pc_en, s_ifid_en, s_ifid_flush, s_idex_en, s_idex_flush, s_exmem_en;
   logic s_memwb_flush, s_mem_err;
   logic [1:0] s_fwd_a, s_fwd_b, s_dbg_state;
   logic [2:0] sat_cnt;

   logic [11:0] ctrl_obs;
   assign ctrl_obs = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush,
                      fwd_a, fwd_b, mem_err};

   int total = 0;
   int bad   = 0;
   int exp_cnt = 0;
   logic [29:0] exp_q[$];

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(16), .R0_HARDWIRED(1'b1)) u_dut (
      .clk(clk), .rst(rst),
      .id_raddr1(id_raddr1), .id_raddr2(id_raddr2), .id_use1(id_use1), .id_use2(id_use2),
      .ex_raddr1(ex_raddr1), .ex_raddr2(ex_raddr2),
      .idex_rfwaddr(idex_rfwaddr), .idex_rfwen(idex_rfwen), .idex_is_load(idex_is_load),
      .exmem_rfwaddr(exmem_rfwaddr), .exmem_rfwen(exmem_rfwen),
      .memwb_rfwaddr(memwb_rfwaddr), .memwb_rfwen(memwb_rfwen),
      .ex_branch_taken(ex_branch_taken), .dm_req(dm_req), .dm_ready(dm_ready),
      .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
      .idex_flush(idex_flush), .exmem_en(exmem_en), .memwb_flush(memwb_flush),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_err(mem_err), .stall_cnt(stall_cnt),
      .dbg_state(dbg_state)
   );

   // Narrow-counter copy to exercise stall_cnt saturation.
   pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(3), .R0_HARDWIRED(1'b1)) u_sat (
      .clk(clk), .rst(rst),
      .id_raddr1(id_raddr1), .id_raddr2(id_raddr2), .id_use1(id_use1), .id_use2(id_use2),
      .ex_raddr1(ex_raddr1), .ex_raddr2(ex_raddr2),
      .idex_rfwaddr(idex_rfwaddr), .idex_rfwen(idex_rfwen), .idex_is_load(idex_is_load),
      .exmem_rfwaddr(exmem_rfwaddr), .exmem_rfwen(exmem_rfwen),
      .memwb_rfwaddr(memwb_rfwaddr), .memwb_rfwen(memwb_rfwen),
      .ex_branch_taken(ex_branch_taken), .dm_req(dm_req), .dm_ready(dm_ready),
      .pc_en(s_pc_en), .ifid_en(s_ifid_en), .ifid_flush(s_ifid_flush), .idex_en(s_idex_en),
      .idex_flush(s_idex_flush), .exmem_en(s_exmem_en), .memwb_flush(s_memwb_flush),
      .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .mem_err(s_mem_err), .stall_cnt(sat_cnt),
      .dbg_state(s_dbg_state)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [11:0] with_fwd(input logic [11:0] base, input logic [1:0] a,
                                            input logic [1:0] b);
      return base | {7'b0, a, b, 1'b0};
   endfunction

   task automatic clear_in();
      id_raddr1 = 4'd0; id_raddr2 = 4'd0; id_use1 = 1'b0; id_use2 = 1'b0;
      ex_raddr1 = 4'd0; ex_raddr2 = 4'd0;
      idex_rfwaddr = 4'd0; idex_rfwen = 1'b0; idex_is_load = 1'b0;
      exmem_rfwaddr = 4'd0; exmem_rfwen = 1'b0;
      memwb_rfwaddr = 4'd0; memwb_rfwen = 1'b0;
      ex_branch_taken = 1'b0; dm_req = 1'b0; dm_ready = 1'b0;
   endtask

   task automatic push_exp(input logic [1:0] st, input logic [11:0] ctrl);
      exp_q.push_back({st, ctrl, 16'(exp_cnt)});
   endtask

   task automatic sample(input string tag);
      logic [29:0] e;
      logic [31:0] sat_exp;
      if (exp_q.size() == 0) begin
         bad++;
         $display("FAIL %s: no expected entry queued", tag);
         return;
      end
      e = exp_q.pop_front();
      sat_exp = 32'(e[15:0]);
      if (sat_exp > 32'd7) sat_exp = 32'd7;
      check_eq({tag, "_ctrl"}, 32'(ctrl_obs), 32'(e[27:16]));
      check_eq({tag, "_cnt"},  32'(stall_cnt), 32'(e[15:0]));
      check_eq({tag, "_sat"},  32'(sat_cnt), sat_exp);
      check_eq({tag, "_st"},   32'(dbg_state), 32'(e[29:28]));
   endtask

   // Inputs are already applied (#1 after posedge); compare at negedge, then advance.
   task automatic step(input string tag, input logic [1:0] st, input logic [11:0] ctrl);
      push_exp(st, ctrl);
      @(negedge clk);
      sample(tag);
      if (ctrl[11] == 1'b0) exp_cnt++;
      @(posedge clk);
      #1;
   endtask

   task automatic release_rst();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      clear_in();
      rst = 1'b0;
      exmem_rfwen = 1'b1; exmem_rfwaddr = 4'd5; ex_raddr1 = 4'd5; ex_branch_taken = 1'b1;
      #12;
      push_exp(S_RUN, C_ZERO);
      sample("reset");
      release_rst();
      clear_in();

      step("idle", S_RUN, C_RUN);

      idex_is_load = 1'b1; idex_rfwen = 1'b1; idex_rfwaddr = 4'd3;
      id_raddr1 = 4'd3; id_use1 = 1'b1;
      step("lu1", S_RUN, C_LU);
      clear_in();
      step("lu_bubble", S_RUN, C_RUN);

      idex_is_load = 1'b1; idex_rfwen = 1'b1; idex_rfwaddr = 4'd3;
      id_raddr2 = 4'd3; id_use2 = 1'b1;
      step("lu2", S_RUN, C_LU);
      id_use2 = 1'b0;
      step("lu_nouse", S_RUN, C_RUN);
      id_use2 = 1'b1; idex_is_load = 1'b0;
      step("lu_noload", S_RUN, C_RUN);
      idex_is_load = 1'b1; idex_rfwaddr = 4'd0; id_raddr2 = 4'd0;
      step("lu_r0", S_RUN, C_RUN);
      clear_in();

      exmem_rfwen = 1'b1; exmem_rfwaddr = 4'd5; memwb_rfwen = 1'b1; memwb_rfwaddr = 4'd5;
      ex_raddr1 = 4'd5; ex_raddr2 = 4'd5;
      step("fwd_prio", S_RUN, with_fwd(C_RUN, 2'b01, 2'b01));
      exmem_rfwen = 1'b0;
      step("fwd_wb", S_RUN, with_fwd(C_RUN, 2'b10, 2'b10));
      exmem_rfwen = 1'b1; exmem_rfwaddr = 4'd0; memwb_rfwaddr = 4'd0;
      ex_raddr1 = 4'd0; ex_raddr2 = 4'd0;
      step("fwd_r0", S_RUN, C_RUN);
      exmem_rfwaddr = 4'd7; memwb_rfwaddr = 4'd9; ex_raddr1 = 4'd9; ex_raddr2 = 4'd7;
      step("fwd_mix", S_RUN, with_fwd(C_RUN, 2'b10, 2'b01));
      clear_in();

      idex_is_load = 1'b1; idex_rfwen = 1'b1; idex_rfwaddr = 4'd4;
      id_raddr1 = 4'd4; id_use1 = 1'b1; ex_branch_taken = 1'b1;
      step("br_lu", S_RUN, C_BR);
      clear_in();

      dm_req = 1'b1; dm_ready = 1'b1;
      step("dm_hit", S_RUN, C_RUN);
      dm_ready = 1'b0; ex_branch_taken = 1'b1;
      step("mw1", S_RUN, C_WAIT);
      step("mw2", S_WAIT, C_WAIT);
      step("mw3", S_WAIT, C_WAIT);
      dm_ready = 1'b1;
      step("mw_resume", S_WAIT, C_BR);
      clear_in();
      step("mw_after", S_RUN, C_RUN);

      dm_req = 1'b1;
      step("to1", S_RUN, C_WAIT);
      step("to2", S_WAIT, C_WAIT);
      step("to3", S_WAIT, C_WAIT);
      step("to4", S_WAIT, C_WAIT);
      step("err1", S_ERR, C_ERR);
      step("err2", S_ERR, C_ERR);
      dm_ready = 1'b1;
      step("err_ready", S_ERR, C_ERR);
      clear_in();
      step("err_idle", S_ERR, C_ERR);
      step("err_hold", S_ERR, C_ERR);

      #2;
      rst = 1'b0;
      exp_cnt = 0;
      #1;
      push_exp(S_RUN, C_ZERO);
      sample("err_rst");
      release_rst();
      step("post_err", S_RUN, C_RUN);

      dm_req = 1'b1;
      step("aw1", S_RUN, C_WAIT);
      step("aw2", S_WAIT, C_WAIT);
      #2;
      rst = 1'b0;
      exp_cnt = 0;
      #1;
      push_exp(S_RUN, C_ZERO);
      sample("async_rst");
      clear_in();
      release_rst();
      step("post_async", S_RUN, C_RUN);
      idex_is_load = 1'b1; idex_rfwen = 1'b1; idex_rfwaddr = 4'd2;
      id_raddr1 = 4'd2; id_use1 = 1'b1;
      step("post_async_lu", S_RUN, C_LU);
      clear_in();
      step("post_async_end", S_RUN, C_RUN);

      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL leftover: %0d expected entries never compared", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
